irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller on a native valid/ready memory bus: synchronises peripheral
// interrupt lines, latches pending bits and arbitrates claims by lowest source index.
module irq_ctrl #(
    parameter int IRQ_NUM = 6
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               mem_valid_i,
    input  logic [31:0]        mem_addr_i,
    input  logic [31:0]        mem_wdata_i,
    input  logic [3:0]         mem_wstrb_i,
    output logic [31:0]        mem_rdata_o,
    output logic               mem_ready_o,
    input  logic [IRQ_NUM-1:0] irq_i,
    output logic               irq_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t             state_r;
    logic               ready_r;
    logic               done_r;
    logic               irq_r;
    logic [31:0]        rdata_r;
    logic [IRQ_NUM-1:0] sync1_r, sync2_r, edge_r;
    logic [IRQ_NUM-1:0] ena_r, mode_r, pend_r, isv_r;

    logic               accept_s, is_write_s, wr_s, rd_s, claim_s, cmp_wr_s, found_s;
    logic [2:0]         sel_s;
    logic [3:0]         claim_id_s;
    logic [31:0]        rd_val_s;
    logic [IRQ_NUM-1:0] rise_s, active_s, claim_oh_s, claim_set_s, w1c_s;
    logic [IRQ_NUM-1:0] mode_chg_s, cmp_clr_s, pend_nxt_s;
    logic               unused_s;

    assign unused_s    = ^{mem_addr_i[31:5], mem_addr_i[1:0]};
    assign mem_ready_o = ready_r;
    assign mem_rdata_o = rdata_r;
    assign irq_o       = irq_r;

    // Bus decode, claim arbitration and next-state of the pending bits.
    always_comb begin
        accept_s   = (state_r == IDLE) && mem_valid_i && !done_r;
        is_write_s = (mem_wstrb_i != 4'h0);
        wr_s       = accept_s && mem_wstrb_i[0];
        rd_s       = accept_s && !is_write_s;
        sel_s      = mem_addr_i[4:2];
        rise_s     = sync2_r & ~edge_r;
        active_s   = pend_r & ena_r & ~isv_r;

        found_s    = 1'b0;
        claim_id_s = 4'd0;
        claim_oh_s = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (active_s[i] && !found_s) begin
                found_s       = 1'b1;
                claim_oh_s[i] = 1'b1;
                claim_id_s    = 4'(i + 1);
            end else begin
                found_s = found_s;
            end
        end

        claim_s     = rd_s && (sel_s == 3'd3) && found_s;
        claim_set_s = claim_s ? claim_oh_s : '0;
        w1c_s       = (wr_s && (sel_s == 3'd2)) ? mem_wdata_i[IRQ_NUM-1:0] : '0;
        mode_chg_s  = (wr_s && (sel_s == 3'd1)) ? (mode_r ^ mem_wdata_i[IRQ_NUM-1:0]) : '0;
        cmp_wr_s    = wr_s && (sel_s == 3'd3);

        // A source whose mode flips starts clean; in edge mode a new edge beats any clear.
        for (int i = 0; i < IRQ_NUM; i++) begin
            cmp_clr_s[i] = cmp_wr_s && (mem_wdata_i == 32'(i + 1));
            if (mode_chg_s[i]) begin
                pend_nxt_s[i] = 1'b0;
            end else if (mode_r[i]) begin
                if (rise_s[i]) begin
                    pend_nxt_s[i] = 1'b1;
                end else if (w1c_s[i] || claim_set_s[i]) begin
                    pend_nxt_s[i] = 1'b0;
                end else begin
                    pend_nxt_s[i] = pend_r[i];
                end
            end else begin
                pend_nxt_s[i] = sync2_r[i];
            end
        end

        case (sel_s)
            3'd0:    rd_val_s = 32'(ena_r);
            3'd1:    rd_val_s = 32'(mode_r);
            3'd2:    rd_val_s = 32'(pend_r);
            3'd3:    rd_val_s = 32'(claim_id_s);
            3'd4:    rd_val_s = 32'(isv_r);
            default: rd_val_s = 32'h0;
        endcase
    end

    // Bus handshake FSM; done_r blocks re-acceptance until the master drops valid.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
            rdata_r <= 32'h0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= accept_s ? ACK : IDLE;
                    ready_r <= accept_s;
                    rdata_r <= rd_s ? rd_val_s : 32'h0;
                end
                ACK: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    rdata_r <= 32'h0;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    rdata_r <= 32'h0;
                end
            endcase
            if (accept_s) begin
                done_r <= 1'b1;
            end else if (!mem_valid_i) begin
                done_r <= 1'b0;
            end else begin
                done_r <= done_r;
            end
        end
    end

    // Two-flop synchroniser followed by the edge-detect history flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_r <= '0;
            sync2_r <= '0;
            edge_r  <= '0;
        end else begin
            sync1_r <= irq_i;
            sync2_r <= sync1_r;
            edge_r  <= sync2_r;
        end
    end

    // Software-visible registers and the aggregated interrupt output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ena_r  <= '0;
            mode_r <= '0;
            pend_r <= '0;
            isv_r  <= '0;
            irq_r  <= 1'b0;
        end else begin
            if (wr_s && (sel_s == 3'd0)) begin
                ena_r <= mem_wdata_i[IRQ_NUM-1:0];
            end else begin
                ena_r <= ena_r;
            end
            if (wr_s && (sel_s == 3'd1)) begin
                mode_r <= mem_wdata_i[IRQ_NUM-1:0];
            end else begin
                mode_r <= mode_r;
            end
            pend_r <= pend_nxt_s;
            isv_r  <= (isv_r | claim_set_s) & ~cmp_clr_s;
            irq_r  <= |active_s;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scenario bench for irq_ctrl: expected read data is queued when a request is
// issued and popped when the controller answers with ready.
module tb_irq_ctrl;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    logic [N-1:0]  irq;
    logic          irq_out;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [31:0]   exp_q[$];

    irq_ctrl #(.IRQ_NUM(N)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .mem_valid_i (mem_valid),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb),
        .mem_rdata_o (mem_rdata),
        .mem_ready_o (mem_ready),
        .irq_i       (irq),
        .irq_o       (irq_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus access, bounded wait for ready, then one idle cycle with valid low.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata);
        logic got;
        got       = 1'b0;
        rdata     = 32'h0;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_ready === 1'b1) begin
                rdata = mem_rdata;
                got   = 1'b1;
                break;
            end
        end
        mem_valid = 1'b0;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL bus_timeout addr=%h got=no_ready exp=ready_within_10", addr);
        end
        tick();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus_xfer(addr, data, 4'hF, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus_xfer(addr, 32'h0, 4'h0, data);
    endtask

    task automatic pulse(input int src);
        irq[src] = 1'b1;
        tick();
        irq[src] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r, e;
        rst_n = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        mem_wstrb = 4'h0; irq = '0;
        repeat (3) tick();
        n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", mem_ready); end
        n_cmp++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata); end
        n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq_out); end
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 5; a++) exp_q.push_back(32'h0);
        for (int a = 0; a < 5; a++) begin
            rd(32'(a * 4), r);
            e = exp_q.pop_front();
            n_cmp++; if (r !== e) begin n_fail++; $display("FAIL reset_reg%0d got=%h exp=%h", a, r, e); end
        end
    endtask

    task automatic test_edge_latency();
        logic [31:0] r, e;
        wr(32'h00, 32'h3F);
        wr(32'h04, 32'h01);
        pulse(0);
        tick();
        tick();
        n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL latency_edge3 got=%b exp=0", irq_out); end
        tick();
        n_cmp++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL latency_edge4 got=%b exp=1", irq_out); end
        exp_q.push_back(32'd1);
        rd(32'h0C, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL edge_claim got=%h exp=%h", r, e); end
        n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL edge_irq_after_claim got=%b exp=0", irq_out); end
        exp_q.push_back(32'h01);
        exp_q.push_back(32'h00);
        rd(32'h10, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL edge_isv got=%h exp=%h", r, e); end
        rd(32'h08, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL edge_pend_after_claim got=%h exp=%h", r, e); end
    endtask

    task automatic test_level();
        logic [31:0] r, e;
        wr(32'h0C, 32'd1);
        wr(32'h00, 32'h04);
        irq[2] = 1'b1;
        repeat (4) tick();
        exp_q.push_back(32'd3);
        exp_q.push_back(32'h04);
        rd(32'h0C, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL level_claim got=%h exp=%h", r, e); end
        wr(32'h08, 32'h04);
        rd(32'h08, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL level_w1c_ignored got=%h exp=%h", r, e); end
        n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL level_irq_in_service got=%b exp=0", irq_out); end
        irq[2] = 1'b0;
        repeat (4) tick();
        exp_q.push_back(32'h00);
        rd(32'h08, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL level_pend_follows got=%h exp=%h", r, e); end
        wr(32'h0C, 32'd3);
        repeat (3) tick();
        n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL level_irq_after_complete got=%b exp=0", irq_out); end
        exp_q.push_back(32'h00);
        rd(32'h10, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL level_isv_cleared got=%h exp=%h", r, e); end
    endtask

    task automatic test_priority();
        logic [31:0] r, e;
        wr(32'h00, 32'h3F);
        wr(32'h04, 32'h3F);
        irq = 6'b010010;
        tick();
        irq = '0;
        repeat (4) tick();
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd0);
        for (int k = 0; k < 3; k++) begin
            rd(32'h0C, r);
            e = exp_q.pop_front();
            n_cmp++; if (r !== e) begin n_fail++; $display("FAIL prio_claim%0d got=%h exp=%h", k, r, e); end
        end
        wr(32'h0C, 32'd7);
        exp_q.push_back(32'h12);
        rd(32'h10, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL prio_isv_bad_complete got=%h exp=%h", r, e); end
        wr(32'h0C, 32'd2);
        wr(32'h0C, 32'd5);
        exp_q.push_back(32'h00);
        rd(32'h10, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL prio_isv_completed got=%h exp=%h", r, e); end
    endtask

    task automatic test_collision();
        logic [31:0] r, e, dummy;
        pulse(0);
        repeat (4) tick();
        // Second edge lands on the same clock edge that performs the W1C.
        pulse(0);
        tick();
        bus_xfer(32'h08, 32'h01, 4'hF, dummy);
        exp_q.push_back(32'h01);
        rd(32'h08, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL collision_set_wins got=%h exp=%h", r, e); end
        wr(32'h08, 32'h01);
        exp_q.push_back(32'h00);
        rd(32'h08, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL collision_plain_w1c got=%h exp=%h", r, e); end
    endtask

    task automatic test_disabled_mode();
        logic [31:0] r, e;
        wr(32'h00, 32'h00);
        pulse(3);
        repeat (4) tick();
        exp_q.push_back(32'h08);
        rd(32'h08, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL disabled_latch got=%h exp=%h", r, e); end
        n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL disabled_irq got=%b exp=0", irq_out); end
        wr(32'h08, 32'h08);
        wr(32'h04, 32'h37);
        irq[3] = 1'b1;
        repeat (4) tick();
        exp_q.push_back(32'h08);
        exp_q.push_back(32'h00);
        rd(32'h08, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL mode_level_pend got=%h exp=%h", r, e); end
        wr(32'h04, 32'h3F);
        rd(32'h08, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL mode_change_clears got=%h exp=%h", r, e); end
        irq[3] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_bus();
        logic [31:0] r, e, seen;
        int readies;
        wr(32'h00, 32'h3F);
        exp_q.push_back(32'h0);
        readies = 0;
        seen = 32'hDEADBEEF;
        mem_addr = 32'h18; mem_wstrb = 4'h0; mem_wdata = 32'h0; mem_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (mem_ready === 1'b1) begin
                readies++;
                seen = mem_rdata;
            end
        end
        mem_valid = 1'b0;
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (seen !== e) begin n_fail++; $display("FAIL bus_hole_rdata got=%h exp=%h", seen, e); end
        n_cmp++; if (readies != 1) begin n_fail++; $display("FAIL bus_held_valid_readies got=%0d exp=1", readies); end
        bus_xfer(32'h00, 32'h00, 4'h2, r);
        exp_q.push_back(32'h3F);
        exp_q.push_back(32'h00);
        rd(32'h00, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL bus_wstrb_ignored got=%h exp=%h", r, e); end
        rd(32'h1C, r);
        e = exp_q.pop_front();
        n_cmp++; if (r !== e) begin n_fail++; $display("FAIL bus_hole_1c got=%h exp=%h", r, e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, e;
        int readies;
        pulse(5);
        repeat (4) tick();
        n_cmp++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL midrst_irq_before got=%b exp=1", irq_out); end
        mem_addr = 32'h00; mem_wstrb = 4'h0; mem_valid = 1'b1;
        tick();
        n_cmp++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ack got=%b exp=1", mem_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b exp=0", mem_ready); end
        n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL midrst_irq got=%b exp=0", irq_out); end
        tick();
        tick();
        n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_held got=%b exp=0", mem_ready); end
        rst_n = 1'b1;
        readies = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (mem_ready === 1'b1) readies++;
        end
        mem_valid = 1'b0;
        tick();
        n_cmp++; if (readies != 1) begin n_fail++; $display("FAIL midrst_new_request got=%0d exp=1", readies); end
        for (int a = 0; a < 5; a++) exp_q.push_back(32'h0);
        for (int a = 0; a < 5; a++) begin
            rd(32'(a * 4), r);
            e = exp_q.pop_front();
            n_cmp++; if (r !== e) begin n_fail++; $display("FAIL midrst_reg%0d got=%h exp=%h", a, r, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_edge_latency();
        test_level();
        test_priority();
        test_collision();
        test_disabled_mode();
        test_bus();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
